// File: rtl/bsg_dmc_ui_burst_adapter.sv
// Whole-burst ready/valid front end for the DMC UI: issues app_* commands, serializes writes, gathers reads.
// Define BSG_DMC_UI_ADAPTER_WRITE_ACK_EN to also return a write acknowledge through the response port.
package bsg_dmc_ui_burst_adapter_pkg;
  typedef enum logic [2:0] {
    e_app_wr = 3'b000,
    e_app_rd = 3'b001
  } app_cmd_e;
endpackage

module bsg_dmc_ui_burst_adapter
  import bsg_dmc_ui_burst_adapter_pkg::*;
#(
  parameter int unsigned ui_addr_width_p    = 28,
  parameter int unsigned ui_data_width_p    = 32,
  parameter int unsigned burst_data_width_p = 128
) (
  input  logic                            ui_clk_i,
  input  logic                            ui_reset_i,
  input  logic                            req_v_i,
  output logic                            req_ready_o,
  input  logic                            req_write_i,
  input  logic [ui_addr_width_p-1:0]      req_addr_i,
  input  logic [burst_data_width_p-1:0]   req_data_i,
  input  logic [burst_data_width_p/8-1:0] req_mask_i,
  output logic                            resp_v_o,
  input  logic                            resp_yumi_i,
  output logic                            resp_write_o,
  output logic [burst_data_width_p-1:0]   resp_data_o,
  output logic [ui_addr_width_p-1:0]      app_addr_o,
  output app_cmd_e                        app_cmd_o,
  output logic                            app_en_o,
  input  logic                            app_rdy_i,
  output logic                            app_wdf_wren_o,
  output logic [ui_data_width_p-1:0]      app_wdf_data_o,
  output logic [ui_data_width_p/8-1:0]    app_wdf_mask_o,
  output logic                            app_wdf_end_o,
  input  logic                            app_wdf_rdy_i,
  input  logic                            app_rd_data_valid_i,
  input  logic [ui_data_width_p-1:0]      app_rd_data_i,
  input  logic                            app_rd_data_end_i
);

  localparam int unsigned beats_lp  = burst_data_width_p / ui_data_width_p;
  localparam int unsigned cnt_w_lp  = (beats_lp > 1) ? $clog2(beats_lp) : 1;
  localparam int unsigned mask_w_lp = ui_data_width_p / 8;
  localparam logic [cnt_w_lp-1:0] last_beat_lp = cnt_w_lp'(beats_lp - 1);

  typedef enum logic [2:0] {e_idle, e_write, e_read_cmd, e_read_data, e_resp} state_e;

  state_e                                   state_q, state_d;
  logic [ui_addr_width_p-1:0]               addr_q, addr_d;
  logic                                     write_q, write_d;
  logic [beats_lp-1:0][ui_data_width_p-1:0] data_q, data_d;
  logic [beats_lp-1:0][mask_w_lp-1:0]       mask_q, mask_d;
  logic [cnt_w_lp-1:0]                      beat_q, beat_d;
  logic                                     cmd_done_q, cmd_done_d;
  logic                                     wdf_done_q, wdf_done_d;

  logic                       req_ready_q, req_ready_d;
  logic                       app_en_q, app_en_d;
  app_cmd_e                   app_cmd_q, app_cmd_d;
  logic                       wren_q, wren_d;
  logic [ui_data_width_p-1:0] wdf_data_q, wdf_data_d;
  logic [mask_w_lp-1:0]       wdf_mask_q, wdf_mask_d;
  logic                       wdf_end_q, wdf_end_d;
  logic                       resp_v_q, resp_v_d;

  logic cmd_fire, wdf_fire, last_beat;
  assign cmd_fire  = app_en_q & app_rdy_i;
  assign wdf_fire  = wren_q & app_wdf_rdy_i;
  assign last_beat = (beat_q == last_beat_lp);

  // State register; datapath and output registers ride along with it
  always_ff @(posedge ui_clk_i or posedge ui_reset_i) begin
    if (ui_reset_i) begin
      state_q     <= e_idle;
      addr_q      <= '0;
      write_q     <= 1'b0;
      data_q      <= '0;
      mask_q      <= '0;
      beat_q      <= '0;
      cmd_done_q  <= 1'b0;
      wdf_done_q  <= 1'b0;
      req_ready_q <= 1'b0;
      app_en_q    <= 1'b0;
      app_cmd_q   <= e_app_wr;
      wren_q      <= 1'b0;
      wdf_data_q  <= '0;
      wdf_mask_q  <= '0;
      wdf_end_q   <= 1'b0;
      resp_v_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
      beat_q      <= beat_d;
      cmd_done_q  <= cmd_done_d;
      wdf_done_q  <= wdf_done_d;
      req_ready_q <= req_ready_d;
      app_en_q    <= app_en_d;
      app_cmd_q   <= app_cmd_d;
      wren_q      <= wren_d;
      wdf_data_q  <= wdf_data_d;
      wdf_mask_q  <= wdf_mask_d;
      wdf_end_q   <= wdf_end_d;
      resp_v_q    <= resp_v_d;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    write_d    = write_q;
    data_d     = data_q;
    mask_d     = mask_q;
    beat_d     = beat_q;
    cmd_done_d = cmd_done_q;
    wdf_done_d = wdf_done_q;
    case (state_q)
      e_idle: begin
        if (req_v_i && req_ready_q) begin
          addr_d     = req_addr_i;
          write_d    = req_write_i;
          data_d     = req_data_i;
          mask_d     = req_mask_i;
          beat_d     = '0;
          cmd_done_d = 1'b0;
          wdf_done_d = 1'b0;
          state_d    = req_write_i ? e_write : e_read_cmd;
        end
      end
      e_write: begin
        if (cmd_fire) cmd_done_d = 1'b1;
        if (wdf_fire) begin
          beat_d = last_beat ? '0 : beat_q + cnt_w_lp'(1);
          if (last_beat) wdf_done_d = 1'b1;
        end
        if (cmd_done_d && wdf_done_d) begin
          // Cleared so a write acknowledge carries zero data
          data_d = '0;
`ifdef BSG_DMC_UI_ADAPTER_WRITE_ACK_EN
          state_d = e_resp;
`else
          state_d = e_idle;
`endif
        end
      end
      e_read_cmd, e_read_data: begin
        if ((state_q == e_read_cmd) && cmd_fire) state_d = e_read_data;
        if (app_rd_data_valid_i) begin
          data_d[beat_q] = app_rd_data_i;
          beat_d = last_beat ? '0 : beat_q + cnt_w_lp'(1);
          if (last_beat) state_d = e_resp;
        end
      end
      e_resp: begin
        if (resp_yumi_i) state_d = e_idle;
      end
      default: state_d = e_idle;
    endcase
  end

  // Output register inputs, decoded from the next state
  always_comb begin
    req_ready_d = (state_d == e_idle);
    app_en_d    = ((state_d == e_write) || (state_d == e_read_cmd)) && !cmd_done_d;
    app_cmd_d   = app_cmd_q;
    if (app_en_d) app_cmd_d = write_d ? e_app_wr : e_app_rd;
    wren_d      = (state_d == e_write) && !wdf_done_d;
    wdf_data_d  = wren_d ? data_d[beat_d] : '0;
    wdf_mask_d  = wren_d ? mask_d[beat_d] : '0;
    wdf_end_d   = wren_d && (beat_d == last_beat_lp);
    resp_v_d    = (state_d == e_resp);
  end

`ifdef BSG_DMC_UI_ADAPTER_WRITE_ACK_EN
  logic resp_write_q;
  always_ff @(posedge ui_clk_i or posedge ui_reset_i) begin
    if (ui_reset_i) resp_write_q <= 1'b0;
    else            resp_write_q <= (state_d == e_resp) && write_d;
  end
  assign resp_write_o = resp_write_q;
`else
  assign resp_write_o = 1'b0;
`endif

  assign req_ready_o    = req_ready_q;
  assign resp_v_o       = resp_v_q;
  assign resp_data_o    = data_q;
  assign app_addr_o     = addr_q;
  assign app_cmd_o      = app_cmd_q;
  assign app_en_o       = app_en_q;
  assign app_wdf_wren_o = wren_q;
  assign app_wdf_data_o = wdf_data_q;
  assign app_wdf_mask_o = wdf_mask_q;
  assign app_wdf_end_o  = wdf_end_q;

`ifndef SYNTHESIS
  always_ff @(posedge ui_clk_i) begin
    if (!ui_reset_i) begin
      if (app_rd_data_valid_i) begin
        assert ((state_q == e_read_cmd) || (state_q == e_read_data))
          else $error("read beat arrived with no read outstanding");
        assert (app_rd_data_end_i == last_beat)
          else $error("app_rd_data_end_i disagrees with beat count");
      end
      if (resp_yumi_i) assert (resp_v_q) else $error("resp_yumi_i without resp_v_o");
    end
  end
`endif

endmodule

// File: tb/tb_bsg_dmc_ui_burst_adapter.sv
// Directed, table-driven bench for bsg_dmc_ui_burst_adapter (28-bit address, 32-bit beats, 128-bit bursts).
module tb_bsg_dmc_ui_burst_adapter;
  import bsg_dmc_ui_burst_adapter_pkg::*;

  localparam int unsigned AW = 28;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 128;

  logic          ui_clk_i = 1'b0;
  logic          ui_reset_i;
  logic          req_v_i, req_ready_o, req_write_i;
  logic [AW-1:0] req_addr_i;
  logic [BW-1:0] req_data_i;
  logic [BW/8-1:0] req_mask_i;
  logic          resp_v_o, resp_yumi_i, resp_write_o;
  logic [BW-1:0] resp_data_o;
  logic [AW-1:0] app_addr_o;
  app_cmd_e      app_cmd_o;
  logic          app_en_o, app_rdy_i;
  logic          app_wdf_wren_o, app_wdf_end_o, app_wdf_rdy_i;
  logic [DW-1:0] app_wdf_data_o;
  logic [DW/8-1:0] app_wdf_mask_o;
  logic          app_rd_data_valid_i, app_rd_data_end_i;
  logic [DW-1:0] app_rd_data_i;

  bsg_dmc_ui_burst_adapter #(
    .ui_addr_width_p(AW), .ui_data_width_p(DW), .burst_data_width_p(BW)
  ) dut (
    .ui_clk_i(ui_clk_i), .ui_reset_i(ui_reset_i),
    .req_v_i(req_v_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_mask_i(req_mask_i),
    .resp_v_o(resp_v_o), .resp_yumi_i(resp_yumi_i), .resp_write_o(resp_write_o),
    .resp_data_o(resp_data_o),
    .app_addr_o(app_addr_o), .app_cmd_o(app_cmd_o), .app_en_o(app_en_o), .app_rdy_i(app_rdy_i),
    .app_wdf_wren_o(app_wdf_wren_o), .app_wdf_data_o(app_wdf_data_o),
    .app_wdf_mask_o(app_wdf_mask_o), .app_wdf_end_o(app_wdf_end_o), .app_wdf_rdy_i(app_wdf_rdy_i),
    .app_rd_data_valid_i(app_rd_data_valid_i), .app_rd_data_i(app_rd_data_i),
    .app_rd_data_end_i(app_rd_data_end_i)
  );

  always #5 ui_clk_i = ~ui_clk_i;

  typedef struct {
    logic            wr;
    logic [AW-1:0]   addr;
    logic [BW-1:0]   data;
    logic [15:0]     mask;
    int              stall;     // cycles app_rdy_i stays low
    logic            toggle;    // wdf_rdy toggles 0/1 each cycle
    logic [3:0][31:0] beats;    // expected write beats, or read beats to drive
    logic [3:0][3:0] bmask;     // expected per-beat write mask
    logic [3:0][3:0] gaps;      // idle cycles before each read beat
    logic [BW-1:0]   exp_resp;
  } vec_t;

  vec_t vecs[5];
  vec_t fresh;
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic send_req(input vec_t v);
    req_v_i = 1'b1; req_write_i = v.wr; req_addr_i = v.addr;
    req_data_i = v.data; req_mask_i = v.mask;
    check("req_ready_idle", req_ready_o, 1);
    @(negedge ui_clk_i);
    req_v_i = 1'b0; req_addr_i = '0; req_data_i = ~v.data; req_mask_i = ~v.mask;
  endtask

  task automatic run_write(input vec_t v);
    int k, stalls, cyc;
    logic cmd_seen;
    k = 0; stalls = 0; cyc = 0; cmd_seen = 1'b0;
    send_req(v);
    check("wr_first_app_en", app_en_o, 1);
    check("wr_first_wren", app_wdf_wren_o, 1);
    while (!(cmd_seen && k == 4) && cyc < 64) begin
      app_rdy_i = (cyc >= v.stall);
      app_wdf_rdy_i = v.toggle ? cyc[0] : 1'b1;
      if (app_en_o) begin
        if (app_rdy_i) begin
          check("wr_cmd_once", cmd_seen, 0);
          check("wr_cmd_addr", app_addr_o, v.addr);
          check("wr_cmd_kind", app_cmd_o, e_app_wr);
          cmd_seen = 1'b1;
        end else stalls++;
      end
      if (app_wdf_wren_o && app_wdf_rdy_i) begin
        if (k < 4) begin
          check("wdf_data", app_wdf_data_o, v.beats[k]);
          check("wdf_mask", app_wdf_mask_o, v.bmask[k]);
          check("wdf_end", app_wdf_end_o, k == 3);
        end else check("wdf_extra_beat", k, 3);
        k++;
      end
      cyc++;
      @(negedge ui_clk_i);
    end
    app_rdy_i = 1'b0; app_wdf_rdy_i = 1'b0;
    check("wr_complete", cmd_seen && (k == 4), 1);
    check("wr_en_stall_cycles", stalls, v.stall);
    check("wr_app_en_off", app_en_o, 0);
    check("wr_wren_off", app_wdf_wren_o, 0);
`ifdef BSG_DMC_UI_ADAPTER_WRITE_ACK_EN
    check("wr_ack_v", resp_v_o, 1);
    check("wr_ack_write", resp_write_o, 1);
    check("wr_ack_data", resp_data_o, 0);
    check("wr_ack_not_ready", req_ready_o, 0);
    resp_yumi_i = 1'b1;
    @(negedge ui_clk_i);
    resp_yumi_i = 1'b0;
    check("wr_ack_done", resp_v_o, 0);
`else
    check("wr_no_resp", resp_v_o, 0);
`endif
    check("wr_ready_back", req_ready_o, 1);
  endtask

  task automatic run_read(input vec_t v);
    app_rdy_i = 1'b1;
    send_req(v);
    check("rd_first_app_en", app_en_o, 1);
    check("rd_cmd_kind", app_cmd_o, e_app_rd);
    check("rd_cmd_addr", app_addr_o, v.addr);
    check("rd_not_ready", req_ready_o, 0);
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < int'(v.gaps[b]); g++) begin
        app_rd_data_valid_i = 1'b0; app_rd_data_end_i = 1'b0;
        @(negedge ui_clk_i);
      end
      app_rd_data_valid_i = 1'b1; app_rd_data_i = v.beats[b]; app_rd_data_end_i = (b == 3);
      @(negedge ui_clk_i);
    end
    app_rd_data_valid_i = 1'b0; app_rd_data_end_i = 1'b0; app_rdy_i = 1'b0;
    check("rd_resp_v", resp_v_o, 1);
    check("rd_resp_data", resp_data_o, v.exp_resp);
    check("rd_resp_write", resp_write_o, 0);
    check("rd_app_en_off", app_en_o, 0);
    for (int h = 0; h < 2; h++) begin
      @(negedge ui_clk_i);
      check("rd_resp_v_hold", resp_v_o, 1);
      check("rd_resp_data_hold", resp_data_o, v.exp_resp);
    end
    resp_yumi_i = 1'b1;
    @(negedge ui_clk_i);
    resp_yumi_i = 1'b0;
    check("rd_resp_done", resp_v_o, 0);
    check("rd_ready_back", req_ready_o, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{wr:1'b1, addr:28'h100, data:128'h00000044_00000033_00000022_00000011, mask:16'h0000,
                stall:0, toggle:1'b0, beats:{32'h44, 32'h33, 32'h22, 32'h11},
                bmask:16'h0000, gaps:16'h0000, exp_resp:'0};
    vecs[1] = '{wr:1'b1, addr:28'h140, data:128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0, mask:16'h0000,
                stall:5, toggle:1'b0, beats:{32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678, 32'h9ABCDEF0},
                bmask:16'h0000, gaps:16'h0000, exp_resp:'0};
    vecs[2] = '{wr:1'b1, addr:28'h180, data:128'h44444444_33333333_22222222_11111111, mask:16'hF0A5,
                stall:2, toggle:1'b1, beats:{32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
                bmask:{4'hF, 4'h0, 4'hA, 4'h5}, gaps:16'h0000, exp_resp:'0};
    vecs[3] = '{wr:1'b0, addr:28'h200, data:'0, mask:16'h0000,
                stall:0, toggle:1'b0, beats:{32'hD, 32'hC, 32'hB, 32'hA},
                bmask:16'h0000, gaps:{4'd1, 4'd2, 4'd1, 4'd0},
                exp_resp:128'h0000000D_0000000C_0000000B_0000000A};
    vecs[4] = '{wr:1'b0, addr:28'h240, data:'0, mask:16'h0000,
                stall:0, toggle:1'b0, beats:{32'h00000000, 32'hFFFFFFFF, 32'h01234567, 32'h89ABCDEF},
                bmask:16'h0000, gaps:16'h0000,
                exp_resp:128'h00000000_FFFFFFFF_01234567_89ABCDEF};
    fresh   = '{wr:1'b0, addr:28'h300, data:'0, mask:16'h0000,
                stall:0, toggle:1'b0, beats:{32'h4, 32'h3, 32'h2, 32'h1},
                bmask:16'h0000, gaps:16'h0000,
                exp_resp:128'h00000004_00000003_00000002_00000001};

    ui_reset_i = 1'b1;
    req_v_i = 1'b0; req_write_i = 1'b0; req_addr_i = '0; req_data_i = '0; req_mask_i = '0;
    resp_yumi_i = 1'b0; app_rdy_i = 1'b0; app_wdf_rdy_i = 1'b0;
    app_rd_data_valid_i = 1'b0; app_rd_data_i = '0; app_rd_data_end_i = 1'b0;
    repeat (2) @(negedge ui_clk_i);
    check("rst_req_ready", req_ready_o, 0);
    check("rst_app_en", app_en_o, 0);
    check("rst_wren", app_wdf_wren_o, 0);
    check("rst_resp_v", resp_v_o, 0);
    check("rst_resp_data", resp_data_o, 0);
    ui_reset_i = 1'b0;
    @(negedge ui_clk_i);
    check("post_rst_ready", req_ready_o, 1);

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].wr) run_write(vecs[i]);
      else            run_read(vecs[i]);
      @(negedge ui_clk_i);
    end

    // Reset in the middle of a read burst, after two beats
    app_rdy_i = 1'b1;
    send_req(vecs[3]);
    app_rd_data_valid_i = 1'b1; app_rd_data_i = 32'h55; app_rd_data_end_i = 1'b0;
    @(negedge ui_clk_i);
    app_rd_data_i = 32'h66;
    @(negedge ui_clk_i);
    app_rd_data_valid_i = 1'b0; app_rdy_i = 1'b0;
    ui_reset_i = 1'b1;
    #1;
    check("midrst_app_en", app_en_o, 0);
    check("midrst_wren", app_wdf_wren_o, 0);
    check("midrst_resp_v", resp_v_o, 0);
    check("midrst_req_ready", req_ready_o, 0);
    check("midrst_resp_data", resp_data_o, 0);
    @(negedge ui_clk_i);
    ui_reset_i = 1'b0;
    @(negedge ui_clk_i);
    check("midrst_ready_back", req_ready_o, 1);
    run_read(fresh);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
